// File: rtl/pea_pkg.sv
// ---------------------------------------------------------------------------
// pea_pkg
// Shared definitions for the processing-element array (PEA) and the blocks
// that sit at its edges.
//   N_BITS        : result word width produced by every PE
//   sink_state_t  : run-control states of the result stream sink
// ---------------------------------------------------------------------------
package pea_pkg;

    localparam int N_BITS = 32;

    typedef enum logic [1:0] {
        SINK_IDLE,
        SINK_RUN,
        SINK_DRAIN,
        SINK_DONE
    } sink_state_t;

endpackage

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
// First-word-fall-through FIFO with occupancy output. A push and a pop in the
// same cycle both take effect, so a full FIFO can accept a word while it
// frees one. A pushed word becomes visible on data_o one cycle later (no
// bypass). clr_i empties the FIFO synchronously and overrides push and pop.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear
//   push_i       : write data_i (ignored when full without a pop)
//   data_i       : word to write
//   pop_i        : discard the head word (ignored when empty)
//   data_o       : head word
//   empty_o      : no words stored
//   full_o       : DEPTH words stored
//   level_o      : number of words stored, 0..DEPTH
// ---------------------------------------------------------------------------
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level == '0);
    assign full_o  = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];
    assign level_o = level;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is cleared on reset so the head output reads zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !clr_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/pe_stream_sink.sv
// ---------------------------------------------------------------------------
// pe_stream_sink
// Downstream end of the PE result stream. Captures results from an edge PE
// into a FIFO, drives the global pea_ready back-pressure, drains the FIFO to
// a valid/ready output stream and signals done after a programmed number of
// results has been accepted and drained.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : begin a run (only honoured in IDLE)
//   cfg_len_i     : results to accept in the run, sampled with start_i
//   flush_i       : synchronous abort, empties FIFO and returns to IDLE
//   pe_res_i      : result word from the PE
//   pe_valid_i    : PE result valid
//   pea_ready_o   : registered global ready for every PE
//   out_data_o    : FIFO head
//   out_valid_o   : FIFO non-empty
//   out_ready_i   : downstream accept
//   busy_o        : a run is in progress
//   done_o        : one-cycle pulse when the run has fully drained
//   level_o       : FIFO occupancy
// ---------------------------------------------------------------------------
module pe_stream_sink #(
    parameter int N_BITS = pea_pkg::N_BITS,
    parameter int DEPTH  = 8,
    parameter int MARGIN = 0,
    parameter int LEN_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         cfg_len_i,
    input  logic                     flush_i,
    input  logic [N_BITS-1:0]        pe_res_i,
    input  logic                     pe_valid_i,
    output logic                     pea_ready_o,
    output logic [N_BITS-1:0]        out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    import pea_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;
    // Ready is only granted while the FIFO will still have more than MARGIN
    // free slots, which keeps the FIFO from ever overflowing.
    localparam logic [LW-1:0] READY_LIMIT = LW'(DEPTH - MARGIN);

    sink_state_t      state;
    sink_state_t      state_next;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic             fifo_empty;
    logic             fifo_full;
    logic             accept;
    logic             last_accept;
    logic             push;
    logic             pop;
    logic             ready_next;

    assign accept      = (state == SINK_RUN) && pe_valid_i && pea_ready_o;
    assign last_accept = accept && ((cnt + LEN_W'(1)) == len);
    assign pop         = !fifo_empty && out_ready_i;
    assign push        = accept && !flush_i && (!fifo_full || pop);

    stream_fifo #(
        .WIDTH (N_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .push_i  (push),
        .data_i  (pe_res_i),
        .pop_i   (pop),
        .data_o  (out_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level)
    );

    assign out_valid_o = !fifo_empty;
    assign level_o     = level;

    // Occupancy after the coming edge; ready is registered from this value so
    // nothing on the input side reaches pea_ready_o combinationally.
    always_comb begin
        level_next = level;
        if (flush_i) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Run control: flush overrides everything; a zero-length run skips RUN.
    always_comb begin
        state_next = state;
        busy_o     = (state != SINK_IDLE);
        done_o     = (state == SINK_DONE);
        if (flush_i) begin
            state_next = SINK_IDLE;
        end else begin
            case (state)
                SINK_IDLE: begin
                    if (start_i) begin
                        state_next = (cfg_len_i == '0) ? SINK_DRAIN : SINK_RUN;
                    end
                end
                SINK_RUN: begin
                    if (last_accept) begin
                        state_next = SINK_DRAIN;
                    end
                end
                SINK_DRAIN: begin
                    if (fifo_empty) begin
                        state_next = SINK_DONE;
                    end
                end
                SINK_DONE: begin
                    state_next = SINK_IDLE;
                end
                default: begin
                    state_next = SINK_IDLE;
                end
            endcase
        end
    end

    // The last accept moves the state out of RUN, which already drops ready.
    assign ready_next = (state_next == SINK_RUN) && (level_next < READY_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= SINK_IDLE;
            len         <= '0;
            cnt         <= '0;
            pea_ready_o <= 1'b0;
        end else begin
            state       <= state_next;
            pea_ready_o <= ready_next;
            if (flush_i) begin
                cnt <= '0;
            end else if ((state == SINK_IDLE) && start_i) begin
                len <= cfg_len_i;
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

endmodule
